// File: rtl/jt12_op_pkg.sv
// Shared constants, index types and ROM generators for the jt12 operator datapath.
package jt12_op_pkg;

  localparam int unsigned OP_LAT = 5;
  localparam real PI = 3.14159265358979323846;

  typedef logic [2:0] ch_t;
  typedef logic [4:0] slot_t;

  // Quarter-wave -log2(sin) in 4.8 fixed point, sampled at odd half-steps
  function automatic logic [11:0] logsin_val(input int i);
    real x;
    x = $itor(2 * i + 1) * PI / 1024.0;
    return 12'($rtoi(-$ln($sin(x)) / $ln(2.0) * 256.0 + 0.5));
  endfunction

  function automatic logic [9:0] exp_val(input int i);
    return 10'($rtoi($pow(2.0, $itor(i) / 256.0) * 1024.0 + 0.5) - 1024);
  endfunction

endpackage

// File: rtl/jt12_op_fb.sv
// Operator-1 self-feedback memory: last two results per channel and the
// scaled feedback phase offset derived from them.
module jt12_op_fb
  import jt12_op_pkg::*;
#(
  parameter int DW = 14,
  parameter int CH = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  ch_t           ch_rd,
  input  logic [2:0]    fb,
  output logic [9:0]    pm,
  input  logic          we,
  input  ch_t           ch_wr,
  input  logic [DW-1:0] din
);

  logic [DW-1:0]        prev     [CH];
  logic [DW-1:0]        prevprev [CH];
  logic [DW-1:0]        prev_rd, pp_rd;
  logic signed [DW:0]   fb_sum, fb_sh;
  logic [3:0]           shamt;
  logic                 unused_fb_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH; i++) begin
        prev[i]     <= '0;
        prevprev[i] <= '0;
      end
    end else if (we && ch_wr < 3'(CH)) begin
      prevprev[ch_wr] <= prev[ch_wr];
      prev[ch_wr]     <= din;
    end
  end

  // Reads see the registered contents, so a same-cycle write is not visible yet
  always_comb begin
    prev_rd = '0;
    pp_rd   = '0;
    if (ch_rd < 3'(CH)) begin
      prev_rd = prev[ch_rd];
      pp_rd   = prevprev[ch_rd];
    end
    fb_sum = {prev_rd[DW-1], prev_rd} + {pp_rd[DW-1], pp_rd};
    shamt  = 4'd10 - {1'b0, fb};
    fb_sh  = fb_sum >>> shamt;
    pm     = (fb == 3'd0) ? '0 : fb_sh[9:0];
  end

  assign unused_fb_hi = ^fb_sh[DW:10];

endmodule

// File: rtl/jt12_op.sv
// Operator output stage: phase modulation, log-sine lookup, attenuation and
// exponential conversion into a signed sample, five-stage pipeline.
module jt12_op
  import jt12_op_pkg::*;
#(
  parameter int DW = 14,
  parameter int CH = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    phase_VIII,
  input  logic [DW-1:0] mod_VIII,
  input  logic          op1_VIII,
  input  logic [2:0]    ch_VIII,
  input  logic [2:0]    fb_VIII,
  input  logic [9:0]    eg_atten_IX,
  output logic [DW-1:0] op_result_XIII
);

  logic [11:0] logsin_rom [256];
  logic [9:0]  exp_rom    [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign logsin_rom[g] = logsin_val(g);
    assign exp_rom[g]    = exp_val(g);
  end

  logic [9:0]  fb_pm, pm_VIII;
  logic        unused_mod;

  logic [9:0]  phase_IX;
  logic        op1_d [OP_LAT];
  ch_t         ch_d  [OP_LAT];
  logic [7:0]  idx_IX;

  logic [11:0] logsin_X, atten_X;
  logic        sign_X, sign_XI, sign_XII;
  logic [13:0] sum_full_X;
  logic [12:0] sum_X, sum_XI;

  logic [7:0]  exp_idx_XI;
  logic [10:0] mant_XI;
  logic [12:0] mag_XI, mag_XII;
  logic [DW-1:0] mag_ext_XII;

  jt12_op_fb #(.DW(DW), .CH(CH)) u_fb (
    .clk   (clk),
    .rst_n (rst_n),
    .ch_rd (ch_VIII),
    .fb    (fb_VIII),
    .pm    (fb_pm),
    .we    (op1_d[OP_LAT-1]),
    .ch_wr (ch_d[OP_LAT-1]),
    .din   (op_result_XIII)
  );

  assign unused_mod = ^{mod_VIII[DW-1:11], mod_VIII[0]};

  always_comb begin
    pm_VIII     = op1_VIII ? fb_pm : mod_VIII[10:1];
    idx_IX      = phase_IX[8] ? ~phase_IX[7:0] : phase_IX[7:0];
    sum_full_X  = {2'b00, logsin_X} + {2'b00, atten_X};
    sum_X       = sum_full_X[13] ? 13'h1FFF : sum_full_X[12:0];
    exp_idx_XI  = ~sum_XI[7:0];
    mant_XI     = {1'b1, exp_rom[exp_idx_XI]};
    mag_XI      = (sum_XI[12:8] >= 5'd13) ? '0 : ({mant_XI, 2'b00} >> sum_XI[12:8]);
    mag_ext_XII = DW'(mag_XII);
  end

  // op1/ch ride alongside the data so the result can be written back at XIII
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_IX       <= '0;
      logsin_X       <= '0;
      atten_X        <= '0;
      sign_X         <= 1'b0;
      sign_XI        <= 1'b0;
      sign_XII       <= 1'b0;
      sum_XI         <= '0;
      mag_XII        <= '0;
      op_result_XIII <= '0;
      for (int unsigned i = 0; i < OP_LAT; i++) begin
        op1_d[i] <= 1'b0;
        ch_d[i]  <= '0;
      end
    end else begin
      phase_IX       <= phase_VIII + pm_VIII;
      op1_d[0]       <= op1_VIII;
      ch_d[0]        <= ch_VIII;
      for (int unsigned i = 1; i < OP_LAT; i++) begin
        op1_d[i] <= op1_d[i-1];
        ch_d[i]  <= ch_d[i-1];
      end
      logsin_X       <= logsin_rom[idx_IX];
      atten_X        <= {eg_atten_IX, 2'b00};
      sign_X         <= phase_IX[9];
      sum_XI         <= sum_X;
      sign_XI        <= sign_X;
      mag_XII        <= mag_XI;
      sign_XII       <= sign_XI;
      op_result_XIII <= sign_XII ? -mag_ext_XII : mag_ext_XII;
    end
  end

endmodule

// File: tb/tb_jt12_op.sv
// Scoreboard bench for jt12_op: expected samples are queued at drive time
// and compared when the pipeline delivers them.
module tb_jt12_op;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  phase_VIII = '0;
  logic [13:0] mod_VIII = '0;
  logic        op1_VIII = 1'b0;
  logic [2:0]  ch_VIII = '0;
  logic [2:0]  fb_VIII = '0;
  logic [9:0]  eg_atten_IX = '0;
  logic [13:0] op_result_XIII;

  always #5 clk = ~clk;

  jt12_op #(.DW(14), .CH(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .phase_VIII     (phase_VIII),
    .mod_VIII       (mod_VIII),
    .op1_VIII       (op1_VIII),
    .ch_VIII        (ch_VIII),
    .fb_VIII        (fb_VIII),
    .eg_atten_IX    (eg_atten_IX),
    .op_result_XIII (op_result_XIII)
  );

  typedef struct {
    int          due;
    logic [13:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ls_t [256];
  int          ex_t [256];
  logic [13:0] m_prev [8];
  logic [13:0] m_pp   [8];
  logic [9:0]  pend_atten = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (op_result_XIII !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d, due %0d)",
                 e.tag, $signed(op_result_XIII), $signed(e.exp), cyc, e.due);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

  function automatic void build_tables();
    for (int i = 0; i < 256; i++) begin
      ls_t[i] = $rtoi(-$log10($sin($itor(2 * i + 1) * 3.14159265358979 / 1024.0))
                      / $log10(2.0) * 256.0 + 0.5);
      ex_t[i] = $rtoi($exp($itor(i) / 256.0 * $ln(2.0)) * 1024.0 + 0.5) - 1024;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_prev[i] = '0;
      m_pp[i]   = '0;
    end
  endfunction

  function automatic logic [13:0] model(input logic [9:0] ph, input logic [13:0] md,
                                        input logic op1, input logic [2:0] ch,
                                        input logic [2:0] fb, input logic [9:0] at);
    int s, pm, p, idx, sum, sh, mant, mag, res;
    if (op1) begin
      s  = (ch < 6) ? int'($signed(m_prev[ch])) + int'($signed(m_pp[ch])) : 0;
      pm = (fb == 0) ? 0 : ((s >>> (10 - int'(fb))) & 1023);
    end else begin
      pm = int'(md[10:1]);
    end
    p    = (int'(ph) + pm) & 1023;
    idx  = p[8] ? 255 - (p & 255) : (p & 255);
    sum  = ls_t[idx] + int'(at) * 4;
    if (sum > 8191) sum = 8191;
    sh   = sum >> 8;
    mant = 1024 + ex_t[255 - (sum & 255)];
    mag  = (sh >= 13) ? 0 : ((mant * 4) >> sh);
    res  = p[9] ? -mag : mag;
    if (op1 && ch < 6) begin
      m_pp[ch]   = m_prev[ch];
      m_prev[ch] = 14'(res);
    end
    return 14'(res);
  endfunction

  // One slot per call; use_k selects a fixed expected value over the model
  task automatic drive(input logic [9:0] ph, input logic [13:0] md, input logic op1,
                       input logic [2:0] ch, input logic [2:0] fb, input logic [9:0] at,
                       input string tag, input logic use_k, input int k);
    exp_t        e;
    logic [13:0] m;
    @(negedge clk);
    eg_atten_IX = pend_atten;
    pend_atten  = at;
    phase_VIII  = ph;
    mod_VIII    = md;
    op1_VIII    = op1;
    ch_VIII     = ch;
    fb_VIII     = fb;
    m     = model(ph, md, op1, ch, fb, at);
    e.due = cyc + 5;
    e.exp = use_k ? 14'(k) : m;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (op_result_XIII !== '0) begin
      errors++;
      $display("FAIL reset_init: got %0d expected 0", $signed(op_result_XIII));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (op_result_XIII !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %0d expected 0", $signed(op_result_XIII));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_silent();
    drive(10'd0, 14'd0, 1'b0, 3'd0, 3'd0, 10'd0, "silent", 1'b1, 25);
    drive(10'd0, 14'd0, 1'b0, 3'd1, 3'd0, 10'd0, "silent_b2b", 1'b1, 25);
  endtask

  task automatic test_peak_sign();
    drive(10'd256, 14'd0, 1'b0, 3'd0, 3'd0, 10'd0, "peak_pos", 1'b1, 8168);
    drive(10'd768, 14'd0, 1'b0, 3'd0, 3'd0, 10'd0, "peak_neg", 1'b1, -8168);
    drive(10'd512, 14'd0, 1'b0, 3'd0, 3'd0, 10'd0, "silent_neg", 1'b1, -25);
    for (int i = 0; i < 8; i++)
      drive(10'($urandom), 14'd0, 1'b0, 3'd3, 3'd0, 10'($urandom_range(0, 200)),
            "sine_rand", 1'b0, 0);
  endtask

  task automatic test_max_atten();
    for (int i = 0; i < 8; i++)
      drive(10'(i * 128 + 5), 14'd0, 1'b0, 3'd0, 3'd0, 10'h3FF, "max_atten", 1'b1, 0);
    drive(10'd256, 14'd0, 1'b0, 3'd0, 3'd0, 10'h3FF, "max_atten_peak", 1'b1, 0);
  endtask

  task automatic test_modulation();
    drive(10'd0,   14'd512, 1'b0, 3'd0, 3'd0, 10'd0, "mod_peak", 1'b1, 8168);
    drive(10'd900, 14'd512, 1'b0, 3'd0, 3'd0, 10'd0, "mod_wrap", 1'b0, 0);
    drive(10'd256, 14'(-512), 1'b0, 3'd0, 3'd0, 10'd0, "mod_neg", 1'b1, 25);
    for (int i = 0; i < 6; i++)
      drive(10'($urandom), 14'($urandom), 1'b0, 3'(i), 3'($urandom), 10'($urandom_range(0, 100)),
            "mod_rand", 1'b0, 0);
  endtask

  // 24-slot frame: op1 slots for ch0..5 plus ch6/ch7, then operator slots
  task automatic run_frame(input int frame, input logic [2:0] fb_ch [6]);
    for (int j = 0; j < 24; j++) begin
      if (j == 2)
        drive(10'd0, 14'($urandom), 1'b1, 3'd2, fb_ch[2], 10'd0,
              (frame == 0) ? "fb_pass1" : "fb_pass", frame == 0, 25);
      else if (j < 6)
        drive(10'($urandom), 14'($urandom), 1'b1, 3'(j), fb_ch[j],
              10'($urandom_range(0, 40)), "fb_other", 1'b0, 0);
      else if (j < 8)
        drive(10'($urandom), 14'($urandom), 1'b1, 3'(j), 3'd7,
              10'($urandom_range(0, 40)), "fb_ch67", 1'b0, 0);
      else
        drive(10'($urandom), 14'($urandom), 1'b0, 3'(j % 6), 3'($urandom),
              10'($urandom_range(0, 60)), "frame_op", 1'b0, 0);
    end
  endtask

  task automatic test_feedback();
    logic [2:0] fb_ch [6];
    fb_ch = '{3'd3, 3'd0, 3'd7, 3'd5, 3'd1, 3'd7};
    for (int f = 0; f < 3; f++) run_frame(f, fb_ch);
  endtask

  task automatic test_reset_midstream();
    logic [2:0] fb_ch [6];
    fb_ch = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    run_frame(1, fb_ch);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_clear();
    pend_atten = '0;
    #1;
    checks++;
    if (op_result_XIII !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %0d expected 0", $signed(op_result_XIII));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, fb_ch);
    run_frame(1, fb_ch);
  endtask

  task automatic drain();
    @(negedge clk);
    eg_atten_IX = pend_atten;
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
  endtask

  initial begin
    build_tables();
    model_clear();
    test_reset();
    test_silent();
    test_peak_sign();
    test_max_atten();
    test_modulation();
    test_feedback();
    test_reset_midstream();
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
